// File: rtl/dmem_mmio_if.sv
// Data-memory port of the core plus the buffered output channel toward the consumer.
interface dmem_mmio_if #(
    parameter int unsigned N = 64
);
    logic         memWrite;
    logic         memRead;
    logic [N-1:0] address;
    logic [N-1:0] writeData;
    logic [N-1:0] readData;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output memWrite, memRead, address, writeData, out_ready,
        input  readData, out_data, out_valid
    );

    modport slave (
        input  memWrite, memRead, address, writeData, out_ready,
        output readData, out_data, out_valid
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data-side memory responder: word RAM plus MMIO (cycle counter, store counter,
// output FIFO with valid/ready drain and overflow drop counter).
module dmem_mmio #(
    parameter int unsigned N          = 64,
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    dmem_mmio_if.slave bus
);
    localparam int unsigned RAM_AW  = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = FIFO_AW + 1;
    localparam int unsigned WA_W    = N - 3;

    localparam logic [WA_W-1:0] WA_CYCLE  = WA_W'(32'h200);
    localparam logic [WA_W-1:0] WA_STORES = WA_W'(32'h201);
    localparam logic [WA_W-1:0] WA_TXDATA = WA_W'(32'h202);
    localparam logic [WA_W-1:0] WA_TXSTAT = WA_W'(32'h203);

    logic [N-1:0]       ram      [RAM_WORDS];
    logic [N-1:0]       fifoMem  [FIFO_DEPTH];
    logic [FIFO_AW-1:0] head;
    logic [FIFO_AW-1:0] tail;
    logic [CNT_W-1:0]   fifoCount;
    logic [15:0]        dropCount;
    logic [N-1:0]       cycleCount;
    logic [N-1:0]       storeCount;

    logic [WA_W-1:0]    wordAddr;
    logic [RAM_AW-1:0]  ramIdx;
    logic               isRam;
    logic               isCycle;
    logic               isStores;
    logic               isTxData;
    logic               isTxStat;
    logic               fifoEmpty;
    logic               fifoFull;
    logic               pop;
    logic               pushReq;
    logic               pushAccept;
    logic               pushDrop;
    logic               ramWrite;
    logic               storesWrite;
    logic [N-1:0]       txStat;
    logic               unusedAddrBits;

    // Byte-offset bits of the address carry no meaning for word accesses.
    assign unusedAddrBits = ^bus.address[2:0];

    // Address decode on the word address; RAM aliases within its window.
    assign wordAddr = bus.address[N-1:3];
    assign ramIdx   = wordAddr[RAM_AW-1:0];
    assign isRam    = wordAddr < WA_CYCLE;
    assign isCycle  = wordAddr == WA_CYCLE;
    assign isStores = wordAddr == WA_STORES;
    assign isTxData = wordAddr == WA_TXDATA;
    assign isTxStat = wordAddr == WA_TXSTAT;

    // FIFO handshake: a full FIFO still accepts a push when the head leaves on the same edge.
    assign fifoEmpty   = fifoCount == '0;
    assign fifoFull    = fifoCount == CNT_W'(FIFO_DEPTH);
    assign pop         = !fifoEmpty && bus.out_ready;
    assign pushReq     = bus.memWrite && isTxData;
    assign pushAccept  = pushReq && (!fifoFull || pop);
    assign pushDrop    = pushReq && fifoFull && !pop;
    assign ramWrite    = bus.memWrite && isRam;
    assign storesWrite = bus.memWrite && isStores;

    assign bus.out_valid = !fifoEmpty;
    assign bus.out_data  = fifoEmpty ? '0 : fifoMem[head];

    // Status word: occupancy, full, empty and drop count.
    always_comb begin
        txStat        = '0;
        txStat[7:0]   = 8'(fifoCount);
        txStat[8]     = fifoFull;
        txStat[9]     = fifoEmpty;
        txStat[31:16] = dropCount;
    end

    // Zero-latency read mux; returns 0 when no read is requested.
    always_comb begin
        bus.readData = '0;
        if (bus.memRead) begin
            if (isRam) begin
                bus.readData = ram[ramIdx];
            end else if (isCycle) begin
                bus.readData = cycleCount;
            end else if (isStores) begin
                bus.readData = storeCount;
            end else if (isTxStat) begin
                bus.readData = txStat;
            end
        end
    end

    // Storage arrays; RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ramWrite) begin
            ram[ramIdx] <= bus.writeData;
        end
        if (pushAccept) begin
            fifoMem[tail] <= bus.writeData;
        end
    end

    // Free-running cycle counter and RAM store counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycleCount <= '0;
            storeCount <= '0;
        end else begin
            cycleCount <= cycleCount + N'(1);
            if (storesWrite) begin
                storeCount <= bus.writeData;
            end else if (ramWrite) begin
                storeCount <= storeCount + N'(1);
            end
        end
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            fifoCount <= '0;
            dropCount <= '0;
        end else begin
            if (pop) begin
                head <= head + FIFO_AW'(1);
            end
            if (pushAccept) begin
                tail <= tail + FIFO_AW'(1);
            end
            fifoCount <= fifoCount + CNT_W'(pushAccept) - CNT_W'(pop);
            if (pushDrop && (dropCount != 16'hFFFF)) begin
                dropCount <= dropCount + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios plus randomized traffic against a queue/array model.
module tb_dmem_mmio;
    localparam int unsigned N  = 64;
    localparam int unsigned RW = 64;
    localparam int unsigned FD = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_mmio_if #(.N(N)) bus();

    dmem_mmio #(.N(N), .RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad = 0;
    bit checkEn = 1'b0;

    // Behavioural model state
    logic [63:0] mRam [RW];
    logic [63:0] mCycle;
    logic [63:0] mStores;
    logic [63:0] mFifo [$];
    int          mDrops;

    logic [63:0] expRead;
    logic [63:0] expData;
    logic        expValid;

    function automatic logic [63:0] modelRead(input logic [63:0] a);
        logic [63:0] wa;
        logic [63:0] st;
        wa = a >> 3;
        if (a < 64'h1000) return mRam[int'(wa % RW)];
        if (wa == 64'h200) return mCycle;
        if (wa == 64'h201) return mStores;
        if (wa == 64'h203) begin
            st = '0;
            st[7:0] = 8'(mFifo.size());
            st[8] = (mFifo.size() == FD);
            st[9] = (mFifo.size() == 0);
            st[31:16] = 16'(mDrops);
            return st;
        end
        return 64'd0;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic setExp();
        expRead  = bus.memRead ? modelRead(bus.address) : 64'd0;
        expValid = mFifo.size() > 0;
        expData  = (mFifo.size() > 0) ? mFifo[0] : 64'd0;
    endtask

    task automatic drive(input logic w, input logic r, input logic [63:0] a,
                         input logic [63:0] d, input logic rdy);
        bus.memWrite  = w;
        bus.memRead   = r;
        bus.address   = a;
        bus.writeData = d;
        bus.out_ready = rdy;
        setExp();
    endtask

    // Advance one clock edge and apply that edge's effects to the model.
    task automatic stepEdge();
        logic        doPop;
        logic        wasFull;
        logic [63:0] a;
        @(posedge clk);
        if (!reset) begin
            doPop   = (mFifo.size() > 0) && bus.out_ready;
            wasFull = (mFifo.size() == FD);
            if (doPop) void'(mFifo.pop_front());
            if (bus.memWrite) begin
                a = bus.address;
                if (a < 64'h1000) begin
                    mRam[int'((a >> 3) % RW)] = bus.writeData;
                    mStores = mStores + 64'd1;
                end else if ((a >> 3) == 64'h201) begin
                    mStores = bus.writeData;
                end else if ((a >> 3) == 64'h202) begin
                    if (!wasFull || doPop) mFifo.push_back(bus.writeData);
                    else if (mDrops < 16'hFFFF) mDrops++;
                end
            end
            mCycle = mCycle + 64'd1;
        end
        #1;
        setExp();
    endtask

    task automatic op(input logic w, input logic r, input logic [63:0] a,
                      input logic [63:0] d, input logic rdy);
        drive(w, r, a, d, rdy);
        stepEdge();
    endtask

    function automatic logic [63:0] randAddr();
        int unsigned sel;
        logic [63:0] low;
        sel = $urandom_range(0, 19);
        low = 64'($urandom_range(0, 7));
        if (sel < 8) return 64'($urandom_range(0, 32'hFFF));
        if (sel < 10) return 64'h1000 | low;
        if (sel < 12) return 64'h1008 | low;
        if (sel < 16) return 64'h1010 | low;
        if (sel < 18) return 64'h1018 | low;
        if (sel == 18) return 64'h1020 | low;
        return {32'($urandom), 32'($urandom)} | 64'h2000;
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            chk("readData", bus.readData, expRead);
            chk("out_valid", 64'(bus.out_valid), 64'(expValid));
            chk("out_data", bus.out_data, expData);
        end
    end

    initial begin
        logic [63:0] aliasAddr [3];
        logic [63:0] got [$];
        logic [63:0] st;
        int rdyPct;

        aliasAddr[0] = 64'h008;
        aliasAddr[1] = 64'h00F;
        aliasAddr[2] = 64'h208;

        mCycle  = '0;
        mStores = '0;
        mDrops  = 0;
        for (int i = 0; i < RW; i++) mRam[i] = '0;
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        checkEn = 1'b1;

        // Reset, then CYCLE after five idle edges
        reset = 1'b1;
        repeat (3) stepEdge();
        reset = 1'b0;
        repeat (5) op(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(1'b0, 1'b1, 64'h1000, 64'd0, 1'b0);
        #2 chk("cycle5", bus.readData, 64'd5);
        stepEdge();

        // Establish known RAM contents, then clear STORES
        for (int i = 0; i < RW; i++) op(1'b1, 1'b0, 64'(i * 8), 64'd0, 1'b0);
        op(1'b1, 1'b0, 64'h1008, 64'd0, 1'b0);

        // RAM round trip and aliasing
        op(1'b1, 1'b0, 64'h008, 64'hDEADBEEF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, aliasAddr[i], 64'd0, 1'b0);
            #2 chk("ramAlias", bus.readData, 64'hDEADBEEF);
            stepEdge();
        end
        drive(1'b0, 1'b1, 64'h1008, 64'd0, 1'b0);
        #2 chk("stores1", bus.readData, 64'd1);
        stepEdge();

        // Simultaneous read and write
        op(1'b1, 1'b0, 64'h010, 64'd7, 1'b0);
        drive(1'b1, 1'b1, 64'h010, 64'd9, 1'b0);
        #2 chk("rwOld", bus.readData, 64'd7);
        stepEdge();
        drive(1'b0, 1'b1, 64'h010, 64'd0, 1'b0);
        #2 chk("rwNew", bus.readData, 64'd9);
        stepEdge();

        // Fill and overflow
        for (int v = 1; v <= 10; v++) op(1'b1, 1'b0, 64'h1010, 64'(v), 1'b0);
        drive(1'b0, 1'b1, 64'h1018, 64'd0, 1'b0);
        #2 st = bus.readData;
        chk("fillOcc", 64'(st[7:0]), 64'd8);
        chk("fillFull", 64'(st[8]), 64'd1);
        chk("fillDrops", 64'(st[31:16]), 64'd2);
        chk("fillHead", bus.out_data, 64'd1);
        stepEdge();

        // Drain with alternating backpressure
        got.delete();
        for (int i = 0; i < 40 && got.size() < 8; i++) begin
            drive(1'b0, 1'b0, 64'd0, 64'd0, (i % 2) == 0);
            #2 if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            stepEdge();
        end
        chk("drainCount", 64'(got.size()), 64'd8);
        for (int k = 0; k < got.size(); k++) chk("drainOrder", got[k], 64'(k + 1));
        drive(1'b0, 1'b1, 64'h1018, 64'd0, 1'b0);
        #2 chk("drainValid", 64'(bus.out_valid), 64'd0);
        chk("drainEmpty", 64'(bus.readData[9]), 64'd1);
        stepEdge();

        // Push and pop together at full
        for (int v = 0; v < 8; v++) op(1'b1, 1'b0, 64'h1010, 64'(256 + v), 1'b0);
        op(1'b1, 1'b0, 64'h1010, 64'h55, 1'b1);
        drive(1'b0, 1'b1, 64'h1018, 64'd0, 1'b0);
        #2 st = bus.readData;
        chk("ppOcc", 64'(st[7:0]), 64'd8);
        chk("ppDrops", 64'(st[31:16]), 64'd2);
        stepEdge();
        got.delete();
        for (int i = 0; i < 20 && got.size() < 8; i++) begin
            drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
            #2 if (bus.out_valid) got.push_back(bus.out_data);
            stepEdge();
        end
        chk("ppCount", 64'(got.size()), 64'd8);
        if (got.size() > 0) chk("ppLast", got[got.size() - 1], 64'h55);

        // Randomized traffic with phases of differing consumer readiness
        for (int ph = 0; ph < 6; ph++) begin
            rdyPct = (ph % 3 == 0) ? 5 : ((ph % 3 == 1) ? 50 : 90);
            repeat (500) begin
                op($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, randAddr(),
                   {32'($urandom), 32'($urandom)}, $urandom_range(0, 99) < rdyPct);
            end
        end

        // Asynchronous reset mid-operation: FIFO and counters clear, RAM is kept
        op(1'b1, 1'b0, 64'h018, 64'h123, 1'b0);
        for (int v = 0; v < 3; v++) op(1'b1, 1'b0, 64'h1010, 64'(v + 7), 1'b0);
        drive(1'b0, 1'b1, 64'h1008, 64'd0, 1'b0);
        #2 reset = 1'b1;
        mFifo.delete();
        mCycle  = '0;
        mStores = '0;
        mDrops  = 0;
        setExp();
        #1 chk("rstValid", 64'(bus.out_valid), 64'd0);
        chk("rstStores", bus.readData, 64'd0);
        stepEdge();
        reset = 1'b0;
        drive(1'b0, 1'b1, 64'h018, 64'd0, 1'b0);
        #2 chk("ramKept", bus.readData, 64'h123);
        stepEdge();
        repeat (200) begin
            op($urandom_range(0, 1) == 1, 1'b1, randAddr(),
               {32'($urandom), 32'($urandom)}, $urandom_range(0, 1) == 1);
        end

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
